// File: rtl/l2_flush_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// l2_flush_sequencer_pkg
// Shared types and default geometry for the L2 flush sequencer.
//   l2_flush_state_t : sequencer FSM states
//   L2_SETS_DEF / L2_WAYS_DEF : default L2 geometry used as parameter defaults
//   L2_SET_BITS / L2_WAY_BITS : index widths matching the default geometry
// -----------------------------------------------------------------------------
package l2_flush_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ISSUE,
        WAIT,
        FINAL,
        DONE
    } l2_flush_state_t;

    localparam int L2_SETS_DEF = 256;
    localparam int L2_WAYS_DEF = 8;
    localparam int L2_SET_BITS = $clog2(L2_SETS_DEF);
    localparam int L2_WAY_BITS = $clog2(L2_WAYS_DEF);

endpackage

// File: rtl/l2_flush_sequencer.sv
// -----------------------------------------------------------------------------
// l2_flush_sequencer
// Walks every L2 set/way on a flush request, issuing one line-flush op at a
// time. Drains the L2 before and after the walk and pulses flush_done.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   l2_flush_valid    flush request valid
//   l2_flush_i        1 = flush all lines, 0 = data lines only
//   l2_flush_ready    request accepted when valid && ready (IDLE only)
//   idle              L2 has no pending MSHR entries / in-flight ops
//   line_req_valid    line-flush op valid (ISSUE state)
//   line_req_ready    datapath accepts the line op
//   flush_set/way     index of the current line op
//   is_flush_all      l2_flush_i latched at accept
//   line_done         current line op fully processed (counted in WAIT only)
//   ongoing_flush     high from accept until the flush_done cycle inclusive
//   flush_done        1-cycle completion pulse
//   flush_cycles      (only with L2_FLUSH_CYCLE_CNT_EN) cycles spent on the
//                     last/current flush, saturating
//
// Optional feature macro: L2_FLUSH_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
module l2_flush_sequencer
    import l2_flush_sequencer_pkg::*;
#(
    parameter int L2_SETS  = L2_SETS_DEF,
    parameter int L2_WAYS  = L2_WAYS_DEF,
    localparam int SET_BITS = $clog2(L2_SETS),
    localparam int WAY_BITS = $clog2(L2_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_flush_valid,
    input  logic                l2_flush_i,
    output logic                l2_flush_ready,
    input  logic                idle,
    output logic                line_req_valid,
    input  logic                line_req_ready,
    output logic [SET_BITS-1:0] flush_set,
    output logic [WAY_BITS-1:0] flush_way,
    output logic                is_flush_all,
    input  logic                line_done,
    output logic                ongoing_flush,
    output logic                flush_done
`ifdef L2_FLUSH_CYCLE_CNT_EN
    ,
    output logic [31:0]         flush_cycles
`endif
);

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(L2_SETS - 1);
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(L2_WAYS - 1);

    l2_flush_state_t     state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic                all_q, all_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            all_q   <= all_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        set_d          = set_q;
        way_d          = way_q;
        all_d          = all_q;
        l2_flush_ready = 1'b0;
        line_req_valid = 1'b0;
        flush_done     = 1'b0;
        case (state_q)
            IDLE: begin
                l2_flush_ready = 1'b1;
                if (l2_flush_valid) begin
                    all_d   = l2_flush_i;
                    set_d   = '0;
                    way_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (idle) state_d = ISSUE;
            end
            ISSUE: begin
                // set/way are registers, so they stay stable while stalled
                line_req_valid = 1'b1;
                if (line_req_ready) state_d = WAIT;
            end
            WAIT: begin
                // Only a line_done seen here advances the walk
                if (line_done) begin
                    if (way_q == LAST_WAY) begin
                        if (set_q == LAST_SET) begin
                            state_d = FINAL;
                        end else begin
                            way_d   = '0;
                            set_d   = set_q + 1'b1;
                            state_d = ISSUE;
                        end
                    end else begin
                        way_d   = way_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FINAL: begin
                // Let writebacks from the last lines retire before reporting
                if (idle) state_d = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ongoing_flush = (state_q != IDLE);
    assign flush_set     = set_q;
    assign flush_way     = way_q;
    assign is_flush_all  = all_q;

`ifdef L2_FLUSH_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // The accept cycle itself counts as the first flush cycle, so loading 1
    // on accept and adding one per non-IDLE cycle covers accept..DONE.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && l2_flush_valid) begin
            cyc_d = 32'd1;
        end else if (ongoing_flush && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end

    assign flush_cycles = cyc_q;
`endif

endmodule
